// File: rtl/pipe_register_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_register_if
//  Description : Handshake bundle for pipe_register. The producer side
//                (in_valid/in_data/in_ready), the consumer side
//                (out_valid/out_data/out_ready), the synchronous flush and the
//                occupancy count travel together.
//                  master : the environment driving the pipe
//                           (drives flush, in_valid, in_data, out_ready)
//                  slave  : the pipe itself
//                           (drives in_ready, out_valid, out_data, count)
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_register_if #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 2
) ();

    logic                         flush;
    logic                         in_valid;
    logic [SIZE-1:0]              in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic [SIZE-1:0]              out_data;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

endinterface
`default_nettype wire

// File: rtl/pipe_register.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_register
//  Description : DEPTH-stage valid/ready pipeline register with bubble
//                collapsing. Each stage holds a valid bit and a SIZE-bit data
//                register; stage 0 is the input side, stage DEPTH-1 drives the
//                output. A stage advances when its successor is empty or is
//                itself advancing, so holes are squeezed out even while the
//                consumer stalls.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous reset, active low
//                bus  - pipe_register_if.slave (flush, producer and consumer
//                       handshakes, occupancy count)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_register #(
    parameter int              SIZE      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [SIZE-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    pipe_register_if.slave     bus
);

    localparam int c_CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_valid;
    logic [SIZE-1:0]  r_data [DEPTH];
    logic [c_CW-1:0]  r_count;

    logic [DEPTH-1:0] w_adv;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [SIZE-1:0]  w_data_nxt [DEPTH];
    logic [c_CW-1:0]  w_count_nxt;

    // Advance chain, resolved from the output stage backwards so each stage
    // sees whether its successor frees up on this edge.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = r_valid[DEPTH-1] & bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = r_valid[i] & (~r_valid[i+1] | w_adv[i+1]);
        end
    end

    // in_ready deliberately ignores in_valid and flush.
    assign w_in_ready = ~r_valid[0] | w_adv[0];
    assign w_push     = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_pop      = w_adv[DEPTH-1] & ~bus.flush;

    always_comb begin
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        if (bus.flush) begin
            // Flush drops every valid bit and cancels all movement; data
            // registers keep whatever they held.
            w_valid_nxt = '0;
            w_count_nxt = '0;
        end else begin
            w_valid_nxt[0] = w_push | (r_valid[0] & ~w_adv[0]);
            if (w_push) begin
                w_data_nxt[0] = bus.in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                w_valid_nxt[i] = w_adv[i-1] | (r_valid[i] & ~w_adv[i]);
                if (w_adv[i-1]) begin
                    w_data_nxt[i] = r_data[i-1];
                end
            end
            w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid[DEPTH-1];
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_register
//  Description : Self-checking bench for pipe_register. Directed vector table
//                on a DEPTH=3 pipe, hand-written flush sequence on DEPTH=2,
//                asynchronous reset sequence, and a scoreboard run over
//                DEPTH 1, 4 and 8 pipes with random handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_register;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- DEPTH=3 main pipe ----------------
    pipe_register_if #(.SIZE(32), .DEPTH(3)) if3 ();
    pipe_register #(.SIZE(32), .DEPTH(3), .RESET_VAL(32'hDEADBEEF)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    // ---------------- DEPTH=2 flush pipe ----------------
    pipe_register_if #(.SIZE(16), .DEPTH(2)) if2 ();
    pipe_register #(.SIZE(16), .DEPTH(2), .RESET_VAL(16'h0000)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // ---------------- random pipes, DEPTH 1/4/8 ----------------
    localparam int RD [3] = '{1, 4, 8};
    logic        rnd_iv   [3];
    logic        rnd_ordy [3];
    logic [31:0] rnd_d    [3];
    logic        rnd_ir   [3];
    logic        rnd_ov   [3];
    logic [31:0] rnd_od   [3];
    logic [3:0]  rnd_cnt  [3];

    for (genvar g = 0; g < 3; g++) begin : g_rand
        pipe_register_if #(.SIZE(32), .DEPTH(RD[g])) rif ();
        pipe_register #(.SIZE(32), .DEPTH(RD[g]), .RESET_VAL(32'h0)) dut (
            .clk (clk),
            .rst (rst),
            .bus (rif)
        );
        assign rif.flush     = 1'b0;
        assign rif.in_valid  = rnd_iv[g];
        assign rif.in_data   = rnd_d[g];
        assign rif.out_ready = rnd_ordy[g];
        assign rnd_ir[g]     = rif.in_ready;
        assign rnd_ov[g]     = rif.out_valid;
        assign rnd_od[g]     = rif.out_data;
        assign rnd_cnt[g]    = 4'(rif.count);
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ir;    // in_ready before the edge
        logic        ov;    // after the edge
        logic [31:0] od;
        logic [1:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [31:0] od, input logic [1:0] cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        if3.flush     = v.fl;
        if3.in_valid  = v.iv;
        if3.in_data   = v.d;
        if3.out_ready = v.ordy;
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(if3.in_ready), 64'(v.ir));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 64'(if3.out_valid), 64'(v.ov));
        chk({tag, " out_data"},  64'(if3.out_data),  64'(v.od));
        chk({tag, " count"},     64'(if3.count),     64'(v.cnt));
    endtask

    task automatic apply2(input logic fl, input logic iv, input logic [15:0] d,
                          input logic ordy, input logic ir, input logic ov,
                          input logic [15:0] od, input logic [1:0] cnt, input string tag);
        if2.flush     = fl;
        if2.in_valid  = iv;
        if2.in_data   = d;
        if2.out_ready = ordy;
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(if2.in_ready), 64'(ir));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 64'(if2.out_valid), 64'(ov));
        chk({tag, " out_data"},  64'(if2.out_data),  64'(od));
        chk({tag, " count"},     64'(if2.count),     64'(cnt));
    endtask

    vec_t vecs [20];

    // scoreboard for random pipes
    logic [31:0] sb_mem [3][16];
    int          sb_wr  [3];
    int          sb_rd  [3];
    int          mcnt   [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic push, pop, exp_ir;

        //            fl iv data          ordy ir ov out_data      cnt
        vecs[0]  = mk(0, 1, 32'hA5A50001, 1,   1, 0, 32'hDEADBEEF, 1);
        vecs[1]  = mk(0, 0, 32'h0,        1,   1, 0, 32'hDEADBEEF, 1);
        vecs[2]  = mk(0, 0, 32'h0,        1,   1, 1, 32'hA5A50001, 1);
        vecs[3]  = mk(0, 0, 32'h0,        1,   1, 0, 32'hA5A50001, 0);
        vecs[4]  = mk(0, 1, 32'h1,        0,   1, 0, 32'hA5A50001, 1);
        vecs[5]  = mk(0, 1, 32'h2,        0,   1, 0, 32'hA5A50001, 2);
        vecs[6]  = mk(0, 1, 32'h3,        0,   1, 1, 32'h1,        3);
        vecs[7]  = mk(0, 1, 32'h4,        0,   0, 1, 32'h1,        3);
        vecs[8]  = mk(0, 1, 32'h4,        0,   0, 1, 32'h1,        3);
        vecs[9]  = mk(0, 1, 32'h4,        1,   1, 1, 32'h2,        3);
        vecs[10] = mk(0, 0, 32'h0,        1,   1, 1, 32'h3,        2);
        vecs[11] = mk(0, 0, 32'h0,        1,   1, 1, 32'h4,        1);
        vecs[12] = mk(0, 0, 32'h0,        1,   1, 0, 32'h4,        0);
        vecs[13] = mk(0, 1, 32'h10,       0,   1, 0, 32'h4,        1);
        vecs[14] = mk(0, 1, 32'h11,       0,   1, 0, 32'h4,        2);
        vecs[15] = mk(0, 1, 32'h12,       0,   1, 1, 32'h10,       3);
        vecs[16] = mk(0, 1, 32'h13,       1,   1, 1, 32'h11,       3);
        vecs[17] = mk(0, 0, 32'h0,        1,   1, 1, 32'h12,       2);
        vecs[18] = mk(1, 1, 32'h99,       1,   1, 0, 32'h12,       0);
        vecs[19] = mk(0, 0, 32'h0,        1,   1, 0, 32'h12,       0);

        rst = 1'b0;
        if3.flush = 1'b0; if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0;
        if2.flush = 1'b0; if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            rnd_iv[j] = 1'b0; rnd_ordy[j] = 1'b0; rnd_d[j] = '0;
            sb_wr[j] = 0; sb_rd[j] = 0; mcnt[j] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(if3.out_valid), 64'd0);
        chk("reset out_data",  64'(if3.out_data),  64'hDEADBEEF);
        chk("reset count",     64'(if3.count),     64'd0);
        chk("reset in_ready",  64'(if3.in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
        if3.in_valid = 1'b0; if3.out_ready = 1'b0; if3.flush = 1'b0;

        // flush while holding two items, with a push and pop requested
        apply2(0, 1, 16'h21, 0, 1, 0, 16'h0000, 1, "d2 push1");
        apply2(0, 1, 16'h22, 0, 1, 1, 16'h0021, 2, "d2 push2");
        apply2(1, 1, 16'h23, 1, 1, 0, 16'h0021, 0, "d2 flush");
        apply2(0, 0, 16'h0,  1, 1, 0, 16'h0021, 0, "d2 after flush");
        apply2(0, 1, 16'h24, 1, 1, 0, 16'h0021, 1, "d2 push3");
        apply2(0, 0, 16'h0,  1, 1, 1, 16'h0024, 1, "d2 out3");
        apply2(0, 0, 16'h0,  1, 1, 0, 16'h0024, 0, "d2 empty");
        if2.out_ready = 1'b0;

        // asynchronous reset between edges with two items in flight
        apply(mk(0, 1, 32'h31, 0, 1, 0, 32'h12, 1), "ar push1");
        apply(mk(0, 1, 32'h32, 0, 1, 0, 32'h12, 2), "ar push2");
        if3.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar out_valid", 64'(if3.out_valid), 64'd0);
        chk("ar count",     64'(if3.count),     64'd0);
        chk("ar out_data",  64'(if3.out_data),  64'hDEADBEEF);
        chk("ar in_ready",  64'(if3.in_ready),  64'd1);
        if3.in_valid = 1'b1; if3.in_data = 32'h55; if3.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("held count",    64'(if3.count),    64'd0);
        chk("held out_data", 64'(if3.out_data), 64'hDEADBEEF);
        if3.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel count", 64'(if3.count), 64'd0);
        apply(mk(0, 1, 32'h41, 1, 1, 0, 32'hDEADBEEF, 1), "rel push");
        apply(mk(0, 0, 32'h0,  1, 1, 0, 32'hDEADBEEF, 1), "rel mid");
        apply(mk(0, 0, 32'h0,  1, 1, 1, 32'h41,       1), "rel out");
        if3.out_ready = 1'b0;

        // random handshakes against the scoreboard
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int j = 0; j < 3; j++) begin
                rnd_iv[j]   = ($urandom % 4) != 0;
                rnd_ordy[j] = ($urandom % 3) != 0;
                rnd_d[j]    = $urandom;
            end
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                // with bubbles collapsed, a stage-0 slot is free exactly when
                // the pipe is not full, or when a full pipe is popping
                exp_ir = (mcnt[j] < RD[j]) || rnd_ordy[j];
                chk($sformatf("rnd d%0d c%0d in_ready", RD[j], cyc), 64'(rnd_ir[j]), 64'(exp_ir));
                push = rnd_iv[j] && exp_ir;
                pop  = rnd_ov[j] && rnd_ordy[j];
                if (pop) begin
                    chk($sformatf("rnd d%0d c%0d pop_nonempty", RD[j], cyc), 64'(mcnt[j] > 0), 64'd1);
                    chk($sformatf("rnd d%0d c%0d out_data", RD[j], cyc), 64'(rnd_od[j]),
                        64'(sb_mem[j][sb_rd[j] % 16]));
                    sb_rd[j]++;
                end
                if (push) begin
                    sb_mem[j][sb_wr[j] % 16] = rnd_d[j];
                    sb_wr[j]++;
                end
                mcnt[j] = mcnt[j] + int'(push) - int'(pop);
            end
            @(posedge clk);
            #1;
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("rnd d%0d c%0d count", RD[j], cyc), 64'(rnd_cnt[j]), 64'(mcnt[j]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
